// File: rtl/mempool_ctrl_regfile_if.sv
// Request/response bus between the cluster peripheral interconnect and the
// cluster control register file. Signal names carry the register file's view.
interface mempool_ctrl_regfile_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [7:0]  req_addr_i;
    logic        req_write_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_wstrb_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_error_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_wstrb_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_wstrb_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o
    );
endinterface

// File: rtl/mempool_ctrl_regfile.sv
// Cluster control register file: EOC, core/group/tile wake-up, TCDM bounds,
// RO-cache enable, flush request handshake, 64-bit cycle counter with a
// coherent hi snapshot, and NumRegions RO-cache region pairs.
// One response in flight; a new request is accepted whenever the current
// response leaves in the same cycle.
module mempool_ctrl_regfile #(
    parameter int unsigned NumCores     = 256,
    parameter int unsigned NumGroups    = 4,
    parameter int unsigned NumTiles     = 64,
    parameter int unsigned NumRegions   = 4,
    parameter logic [31:0] TCDMBaseAddr = 32'h0,
    parameter logic [31:0] TCDMSize     = 32'h10_0000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    mempool_ctrl_regfile_if.slave    bus,
    output logic [31:0]              eoc_o,
    output logic                     eoc_valid_o,
    output logic [NumCores-1:0]      wake_up_o,
    output logic [31:0]              num_cores_o,
    output logic                     ro_cache_enable_o,
    output logic                     flush_valid_o,
    input  logic                     flush_ready_i,
    output logic [NumRegions*32-1:0] region_start_o,
    output logic [NumRegions*32-1:0] region_end_o
);

    localparam int unsigned CoresPerTile  = NumCores / NumTiles;
    localparam int unsigned TilesPerGroup = NumTiles / NumGroups;
    localparam int unsigned CoresPerGroup = NumCores / NumGroups;

    // Word offsets (byte offset >> 2)
    localparam logic [5:0] WEoc        = 6'h00;
    localparam logic [5:0] WWake       = 6'h01;
    localparam logic [5:0] WGroup      = 6'h02;
    localparam logic [5:0] WTile       = 6'h03;
    localparam logic [5:0] WTcdmStart  = 6'h04;
    localparam logic [5:0] WTcdmEnd    = 6'h05;
    localparam logic [5:0] WNumCores   = 6'h06;
    localparam logic [5:0] WCacheEn    = 6'h07;
    localparam logic [5:0] WFlush      = 6'h08;
    localparam logic [5:0] WCycleLo    = 6'h09;
    localparam logic [5:0] WCycleHi    = 6'h0A;
    localparam logic [5:0] WRegionBase = 6'h0C;

    localparam logic [NumCores-1:0] OneCore = NumCores'(1);

    typedef enum logic {FlushIdle, FlushReq} flush_state_e;

    logic [31:0] eoc_q, wake_reg_q, wake_group_q, wake_tile_q, cache_en_q;
    logic [31:0] region_start_q [NumRegions];
    logic [31:0] region_end_q   [NumRegions];
    logic [63:0] cycle_q;
    logic [31:0] cycle_hi_q;
    logic [NumCores-1:0] wake_q, wake_d;
    flush_state_e state_q, state_d;
    logic        flush_busy;
    logic        rsp_valid_q, rsp_error_q;
    logic [31:0] rsp_rdata_q;

    logic [5:0]  word;
    logic        accept, hit, ro, wr_en, flush_start;
    logic [31:0] cur, merged;
    logic        unused_addr;

    function automatic logic [31:0] region_start_rst(input int i);
        return 32'h8000_0000 + 32'(i) * 32'h2000_0000;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] wdata,
                                               input logic [3:0] strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? wdata[8*b +: 8] : old[8*b +: 8];
        end
        return res;
    endfunction

    // 04: single core index, or all-ones for every core
    function automatic logic [NumCores-1:0] wake_core(input logic [31:0] v);
        logic [NumCores-1:0] res;
        res = '0;
        if (v == 32'hFFFF_FFFF) begin
            res = '1;
        end else if (v < 32'(NumCores)) begin
            res = OneCore << v;
        end
        return res;
    endfunction

    // 08: one bit per group; any bit above the group count cancels the wake
    function automatic logic [NumCores-1:0] wake_group(input logic [31:0] v);
        logic [NumCores-1:0] res;
        res = '0;
        if (v == 32'hFFFF_FFFF) begin
            res = '1;
        end else if ((v >> NumGroups) == 32'd0) begin
            for (int g = 0; g < NumGroups; g++) begin
                if (((v >> g) & 32'd1) != 32'd0) begin
                    res[g*CoresPerGroup +: CoresPerGroup] = '1;
                end
            end
        end
        return res;
    endfunction

    // 0C: group mask in the upper half, tile-in-group mask in the lower half
    function automatic logic [NumCores-1:0] wake_tile(input logic [31:0] v);
        logic [NumCores-1:0] res;
        logic [15:0]         gm, tm;
        logic                gsel;
        res = '0;
        gm  = v[31:16];
        tm  = v[15:0];
        for (int g = 0; g < NumGroups; g++) begin
            gsel = (gm == 16'hFFFF) || (((gm >> g) & 16'd1) != 16'd0);
            for (int t = 0; t < TilesPerGroup; t++) begin
                if (gsel && (((tm >> t) & 16'd1) != 16'd0)) begin
                    res[(g*TilesPerGroup + t)*CoresPerTile +: CoresPerTile] = '1;
                end
            end
        end
        return res;
    endfunction

    assign word         = bus.req_addr_i[7:2];
    assign unused_addr  = ^bus.req_addr_i[1:0];
    assign bus.req_ready_o = ~rsp_valid_q | bus.rsp_ready_i;
    assign accept       = bus.req_valid_i & bus.req_ready_o;
    assign merged       = byte_merge(cur, bus.req_wdata_i, bus.req_wstrb_i);
    assign wr_en        = accept & bus.req_write_i & hit & ~ro & (|bus.req_wstrb_i);
    assign flush_start  = wr_en & (word == WFlush) & bus.req_wstrb_i[0] & bus.req_wdata_i[0];

    // Address decode: hit/read-only flags and current register value
    always_comb begin
        hit = 1'b1;
        ro  = 1'b0;
        cur = '0;
        case (word)
            WEoc:       cur = eoc_q;
            WWake:      cur = wake_reg_q;
            WGroup:     cur = wake_group_q;
            WTile:      cur = wake_tile_q;
            WTcdmStart: begin cur = TCDMBaseAddr;            ro = 1'b1; end
            WTcdmEnd:   begin cur = TCDMBaseAddr + TCDMSize; ro = 1'b1; end
            WNumCores:  begin cur = 32'(NumCores);           ro = 1'b1; end
            WCacheEn:   cur = cache_en_q;
            WFlush:     cur = {31'b0, flush_busy};
            WCycleLo:   begin cur = cycle_q[31:0];           ro = 1'b1; end
            WCycleHi:   begin cur = cycle_hi_q;              ro = 1'b1; end
            default: begin
                hit = 1'b0;
                for (int i = 0; i < NumRegions; i++) begin
                    if (word == 6'(WRegionBase + 6'(2*i))) begin
                        hit = 1'b1;
                        cur = region_start_q[i];
                    end
                    if (word == 6'(WRegionBase + 6'(2*i + 1))) begin
                        hit = 1'b1;
                        cur = region_end_q[i];
                    end
                end
            end
        endcase
    end

    // Byte-merged writes into the read/write registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            eoc_q        <= '0;
            wake_reg_q   <= '0;
            wake_group_q <= '0;
            wake_tile_q  <= '0;
            cache_en_q   <= 32'd1;
            for (int i = 0; i < NumRegions; i++) begin
                region_start_q[i] <= region_start_rst(i);
                region_end_q[i]   <= region_start_rst(i) + 32'h1000;
            end
        end else if (wr_en) begin
            case (word)
                WEoc:     eoc_q        <= merged;
                WWake:    wake_reg_q   <= merged;
                WGroup:   wake_group_q <= merged;
                WTile:    wake_tile_q  <= merged;
                WCacheEn: cache_en_q   <= merged;
                default: begin
                    for (int i = 0; i < NumRegions; i++) begin
                        if (word == 6'(WRegionBase + 6'(2*i)))     region_start_q[i] <= merged;
                        if (word == 6'(WRegionBase + 6'(2*i + 1))) region_end_q[i]   <= merged;
                    end
                end
            endcase
        end
    end

    // Wake-up pulse selected by the merged value of the accepted write
    always_comb begin
        wake_d = '0;
        if (wr_en) begin
            case (word)
                WWake:   wake_d = wake_core(merged);
                WGroup:  wake_d = wake_group(merged);
                WTile:   wake_d = wake_tile(merged);
                default: wake_d = '0;
            endcase
        end
    end

    // Register the wake pulse so it lasts exactly one cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) wake_q <= '0;
        else       wake_q <= wake_d;
    end

    // Free-running cycle counter and hi snapshot taken on a lo read
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cycle_q    <= '0;
            cycle_hi_q <= '0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
            if (accept && !bus.req_write_i && word == WCycleLo) cycle_hi_q <= cycle_q[63:32];
        end
    end

    // Flush FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= FlushIdle;
        else       state_q <= state_d;
    end

    // Flush FSM next state; a flush write while requesting is absorbed
    always_comb begin
        state_d = state_q;
        case (state_q)
            FlushIdle: if (flush_start)   state_d = FlushReq;
            FlushReq:  if (flush_ready_i) state_d = FlushIdle;
            default:                      state_d = FlushIdle;
        endcase
    end

    // Flush FSM outputs
    always_comb begin
        flush_valid_o = (state_q == FlushReq);
        flush_busy    = (state_q == FlushReq);
    end

    // Response register: loads on acceptance, holds until taken
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_error_q <= ~hit | (bus.req_write_i & ro);
            rsp_rdata_q <= (hit && !bus.req_write_i) ? cur : 32'd0;
        end else if (bus.rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_error_o = rsp_error_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;

    assign eoc_o             = {1'b0, eoc_q[31:1]};
    assign eoc_valid_o       = eoc_q[0];
    assign wake_up_o         = wake_q;
    assign num_cores_o       = 32'(NumCores);
    assign ro_cache_enable_o = cache_en_q[0];

    for (genvar i = 0; i < NumRegions; i++) begin : g_region_out
        assign region_start_o[32*i +: 32] = region_start_q[i];
        assign region_end_o[32*i +: 32]   = region_end_q[i];
    end

endmodule

// File: tb/tb_mempool_ctrl_regfile.sv
// Testbench for mempool_ctrl_regfile: responses are checked in order against
// a queue of expected {error, rdata}; side-band outputs are checked inline.
module tb_mempool_ctrl_regfile;
    localparam int NC = 256;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush_ready = 1'b0;
    logic [31:0]      eoc, num_cores;
    logic             eoc_valid, ro_cache_enable, flush_valid;
    logic [NC-1:0]    wake_up;
    logic [NR*32-1:0] region_start, region_end;

    int n_vec = 0;
    int n_err = 0;
    logic [32:0] exp_q[$];

    mempool_ctrl_regfile_if bus();

    mempool_ctrl_regfile #(
        .NumCores(NC), .NumGroups(4), .NumTiles(64), .NumRegions(NR),
        .TCDMBaseAddr(32'h0), .TCDMSize(32'h10_0000)
    ) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus),
        .eoc_o(eoc), .eoc_valid_o(eoc_valid), .wake_up_o(wake_up),
        .num_cores_o(num_cores), .ro_cache_enable_o(ro_cache_enable),
        .flush_valid_o(flush_valid), .flush_ready_i(flush_ready),
        .region_start_o(region_start), .region_end_o(region_end)
    );

    always #5 clk = ~clk;

    // Response monitor: a response seen valid and ready here leaves at the next edge
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid_o && bus.rsp_ready_i) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rsp_unexpected: got rdata=%h err=%b with nothing outstanding",
                         bus.rsp_rdata_o, bus.rsp_error_o);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                if ({bus.rsp_error_o, bus.rsp_rdata_o} !== e) begin
                    n_err++;
                    $display("FAIL rsp_data: got err=%b rdata=%h, required err=%b rdata=%h",
                             bus.rsp_error_o, bus.rsp_rdata_o, e[32], e[31:0]);
                end
            end
        end
    end

    // Drive one request from a non-edge time; returns 1 time unit after acceptance
    task automatic do_req(input logic [7:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s, input logic [31:0] er, input logic ee);
        int t;
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = a;
        bus.req_write_i = w;
        bus.req_wdata_i = d;
        bus.req_wstrb_i = s;
        exp_q.push_back({ee, er});
        t = 0;
        while (!bus.req_ready_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.req_ready_o) begin
            n_vec++;
            n_err++;
            $display("FAIL req_timeout: addr=%h never accepted", a);
        end
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if (bus.req_ready_o !== 1'b1 || bus.rsp_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_handshake: ready=%b valid=%b, required 1/0", bus.req_ready_o, bus.rsp_valid_o);
        end
        n_vec++;
        if (flush_valid !== 1'b0 || wake_up !== '0) begin
            n_err++;
            $display("FAIL reset_flush_wake: flush=%b wake=%h, required 0/0", flush_valid, wake_up);
        end
        n_vec++;
        if (eoc !== 32'd0 || eoc_valid !== 1'b0 || ro_cache_enable !== 1'b1 || num_cores !== 32'd256) begin
            n_err++;
            $display("FAIL reset_outputs: eoc=%h ev=%b en=%b nc=%h, required 0/0/1/100",
                     eoc, eoc_valid, ro_cache_enable, num_cores);
        end
        n_vec++;
        if (region_start[31:0] !== 32'h8000_0000 || region_end[127:96] !== 32'hE000_1000) begin
            n_err++;
            $display("FAIL reset_regions: start0=%h end3=%h, required 80000000/e0001000",
                     region_start[31:0], region_end[127:96]);
        end
        do_req(8'h00, 1'b0, 0, 4'h0, 32'h0, 1'b0);
        do_req(8'h10, 1'b0, 0, 4'h0, 32'h0, 1'b0);
        do_req(8'h14, 1'b0, 0, 4'h0, 32'h0010_0000, 1'b0);
        do_req(8'h18, 1'b0, 0, 4'h0, 32'd256, 1'b0);
        do_req(8'h1C, 1'b0, 0, 4'h0, 32'd1, 1'b0);
        do_req(8'h20, 1'b0, 0, 4'h0, 32'd0, 1'b0);
        do_req(8'h28, 1'b0, 0, 4'h0, 32'd0, 1'b0);
        do_req(8'h30, 1'b0, 0, 4'h0, 32'h8000_0000, 1'b0);
        do_req(8'h3C, 1'b0, 0, 4'h0, 32'hA000_1000, 1'b0);
        do_req(8'h2C, 1'b0, 0, 4'h0, 32'h0, 1'b1);
        do_req(8'h50, 1'b0, 0, 4'h0, 32'h0, 1'b1);
    endtask

    task automatic test_wake_core();
        logic [NC-1:0] e;
        for (int k = 0; k < 3; k++) begin
            logic [31:0] v;
            v = (k == 0) ? 32'd5 : (k == 1) ? 32'hFFFF_FFFF : 32'd256;
            e = (k == 0) ? (NC'(1) << 5) : (k == 1) ? '1 : '0;
            do_req(8'h04, 1'b1, v, 4'hF, 32'h0, 1'b0);
            @(negedge clk);
            n_vec++;
            if (wake_up !== e) begin
                n_err++;
                $display("FAIL wake_core_%0d: got %h required %h", k, wake_up, e);
            end
            @(negedge clk);
            n_vec++;
            if (wake_up !== '0) begin
                n_err++;
                $display("FAIL wake_core_len_%0d: got %h required 0", k, wake_up);
            end
        end
    endtask

    task automatic test_wake_tile_group();
        logic [NC-1:0] e;
        e = '0;
        for (int c = 64; c < 68; c++) e[c] = 1'b1;
        for (int c = 76; c < 80; c++) e[c] = 1'b1;
        do_req(8'h0C, 1'b1, 32'h0002_0009, 4'hF, 32'h0, 1'b0);
        @(negedge clk);
        n_vec++;
        if (wake_up !== e) begin
            n_err++;
            $display("FAIL wake_tile: got %h required %h", wake_up, e);
        end
        e = '0;
        for (int g = 0; g < 4; g++) for (int c = 0; c < 4; c++) e[g*64 + c] = 1'b1;
        do_req(8'h0C, 1'b1, 32'hFFFF_0001, 4'hF, 32'h0, 1'b0);
        @(negedge clk);
        n_vec++;
        if (wake_up !== e) begin
            n_err++;
            $display("FAIL wake_tile_allgroups: got %h required %h", wake_up, e);
        end
        do_req(8'h08, 1'b1, 32'h0000_0010, 4'hF, 32'h0, 1'b0);
        @(negedge clk);
        n_vec++;
        if (wake_up !== '0) begin
            n_err++;
            $display("FAIL wake_group_none: got %h required 0", wake_up);
        end
        e = '0;
        for (int c = 64; c < 128; c++) e[c] = 1'b1;
        do_req(8'h08, 1'b1, 32'h0000_0002, 4'hF, 32'h0, 1'b0);
        @(negedge clk);
        n_vec++;
        if (wake_up !== e) begin
            n_err++;
            $display("FAIL wake_group1: got %h required %h", wake_up, e);
        end
    endtask

    task automatic test_flush();
        int cnt;
        flush_ready = 1'b0;
        do_req(8'h20, 1'b1, 32'd1, 4'h1, 32'h0, 1'b0);
        cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            flush_ready = (i == 6);
            if (flush_valid) cnt++;
        end
        flush_ready = 1'b0;
        n_vec++;
        if (cnt != 6) begin
            n_err++;
            $display("FAIL flush_len: got %0d cycles required 6", cnt);
        end
        do_req(8'h20, 1'b1, 32'd1, 4'h1, 32'h0, 1'b0);
        do_req(8'h20, 1'b0, 0, 4'h0, 32'd1, 1'b0);
        do_req(8'h20, 1'b1, 32'd1, 4'h1, 32'h0, 1'b0);
        do_req(8'h20, 1'b0, 0, 4'h0, 32'd1, 1'b0);
        @(negedge clk);
        flush_ready = 1'b1;
        @(negedge clk);
        flush_ready = 1'b0;
        n_vec++;
        if (flush_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_drop: got %b required 0", flush_valid);
        end
        @(negedge clk);
        n_vec++;
        if (flush_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_no_requeue: got %b required 0", flush_valid);
        end
        do_req(8'h20, 1'b0, 0, 4'h0, 32'd0, 1'b0);
    endtask

    task automatic test_cycle();
        force dut.cycle_q = 64'h0000_0001_FFFF_FFFF;
        do_req(8'h24, 1'b0, 0, 4'h0, 32'hFFFF_FFFF, 1'b0);
        release dut.cycle_q;
        do_req(8'h28, 1'b0, 0, 4'h0, 32'h0000_0001, 1'b0);
        do_req(8'h24, 1'b1, 32'h1234, 4'hF, 32'h0, 1'b1);
    endtask

    task automatic test_back_to_back();
        bus.rsp_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        bus.rsp_ready_i = 1'b0;
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 8'h18;
        bus.req_write_i = 1'b0;
        bus.req_wstrb_i = 4'h0;
        exp_q.push_back({1'b0, 32'd256});
        @(posedge clk);
        #1;
        bus.req_addr_i = 8'h1C;
        exp_q.push_back({1'b0, 32'd1});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_vec++;
            if (bus.req_ready_o !== 1'b0 || bus.rsp_valid_o !== 1'b1 || bus.rsp_rdata_o !== 32'd256) begin
                n_err++;
                $display("FAIL backpressure_%0d: ready=%b valid=%b rdata=%h, required 0/1/100",
                         k, bus.req_ready_o, bus.rsp_valid_o, bus.rsp_rdata_o);
            end
        end
        @(posedge clk);
        #1;
        bus.rsp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        do_req(8'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b1);
        do_req(8'h10, 1'b0, 0, 4'h0, 32'h0, 1'b0);
        do_req(8'h00, 1'b1, 32'h0303, 4'b0001, 32'h0, 1'b0);
        do_req(8'h00, 1'b0, 0, 4'h0, 32'h03, 1'b0);
        n_vec++;
        if (eoc !== 32'd1 || eoc_valid !== 1'b1) begin
            n_err++;
            $display("FAIL eoc_out: eoc=%h valid=%b, required 1/1", eoc, eoc_valid);
        end
    endtask

    task automatic test_strobes();
        do_req(8'h1C, 1'b1, 32'h0, 4'h0, 32'h0, 1'b0);
        do_req(8'h1C, 1'b0, 0, 4'h0, 32'd1, 1'b0);
        do_req(8'h04, 1'b1, 32'd5, 4'h0, 32'h0, 1'b0);
        @(negedge clk);
        n_vec++;
        if (wake_up !== '0) begin
            n_err++;
            $display("FAIL wstrb0_wake: got %h required 0", wake_up);
        end
        do_req(8'h1C, 1'b1, 32'h0, 4'b0001, 32'h0, 1'b0);
        n_vec++;
        if (ro_cache_enable !== 1'b0) begin
            n_err++;
            $display("FAIL cache_disable: got %b required 0", ro_cache_enable);
        end
        do_req(8'h30, 1'b1, 32'h1200_0000, 4'b1000, 32'h0, 1'b0);
        do_req(8'h30, 1'b0, 0, 4'h0, 32'h1200_0000, 1'b0);
        n_vec++;
        if (region_start[31:0] !== 32'h1200_0000) begin
            n_err++;
            $display("FAIL region_merge: got %h required 12000000", region_start[31:0]);
        end
    endtask

    task automatic test_reset_mid();
        bus.rsp_ready_i = 1'b1;
        flush_ready = 1'b0;
        do_req(8'h20, 1'b1, 32'd1, 4'h1, 32'h0, 1'b0);
        do_req(8'h04, 1'b1, 32'd7, 4'hF, 32'h0, 1'b0);
        bus.rsp_ready_i = 1'b0;
        #1;
        n_vec++;
        if (flush_valid !== 1'b1 || wake_up[7] !== 1'b1 || bus.rsp_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset: flush=%b wake7=%b rsp=%b, required 1/1/1",
                     flush_valid, wake_up[7], bus.rsp_valid_o);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (flush_valid !== 1'b0 || wake_up !== '0 || bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset: flush=%b wake=%h rsp=%b ready=%b, required 0/0/0/1",
                     flush_valid, wake_up, bus.rsp_valid_o, bus.req_ready_o);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus.rsp_ready_i = 1'b1;
        n_vec++;
        if (ro_cache_enable !== 1'b1 || eoc !== 32'd0 || eoc_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_out: en=%b eoc=%h ev=%b, required 1/0/0", ro_cache_enable, eoc, eoc_valid);
        end
        do_req(8'h1C, 1'b0, 0, 4'h0, 32'd1, 1'b0);
        do_req(8'h30, 1'b0, 0, 4'h0, 32'h8000_0000, 1'b0);
        do_req(8'h00, 1'b0, 0, 4'h0, 32'h0, 1'b0);
        do_req(8'h04, 1'b0, 0, 4'h0, 32'h0, 1'b0);
        do_req(8'h28, 1'b0, 0, 4'h0, 32'h0, 1'b0);
        do_req(8'h20, 1'b0, 0, 4'h0, 32'h0, 1'b0);
    endtask

    initial begin
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = 8'h0;
        bus.req_write_i = 1'b0;
        bus.req_wdata_i = 32'h0;
        bus.req_wstrb_i = 4'h0;
        bus.rsp_ready_i = 1'b1;
        #22;
        rst = 1'b0;
        test_reset();
        test_wake_core();
        test_wake_tile_group();
        test_flush();
        test_cycle();
        test_back_to_back();
        test_strobes();
        test_reset_mid();
        repeat (3) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rsp_drain: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
